// File: rtl/div_r2_iter_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state type,
// iteration/counter sizing helpers and the quotient-bits-per-cycle legality test.
package fpu_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Number of RUN cycles needed to retire dw quotient bits at bpc bits per cycle.
  function automatic int div_iter(input int dw, input int bpc);
    return dw / bpc;
  endfunction

  // Counter width able to hold 0..ITER inclusive.
  function automatic int div_cnt_w(input int dw, input int bpc);
    return $clog2((dw / bpc) + 1);
  endfunction

  // Only 1, 2 or 4 bits per cycle are supported, and they must tile the dividend.
  function automatic bit div_bpc_legal(input int dw, input int vw, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((dw % bpc) == 0) && (vw <= dw);
  endfunction

endpackage

// File: rtl/div_r2_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_r2_step #(
  parameter int VW = 24
) (
  input  logic [VW:0]   prem_i,
  input  logic          qmsb_i,
  input  logic [VW-1:0] div_i,
  output logic [VW:0]   prem_o,
  output logic          qbit_o
);

  logic [VW+1:0] shifted;
  logic [VW:0]   trial;

  // The incoming remainder is always below the divisor, so the shifted value
  // fits in VW+1 bits; the extra top bit only keeps the compare exact.
  always_comb begin
    shifted = {prem_i, qmsb_i};
    qbit_o  = (shifted >= {2'b00, div_i});
    trial   = shifted[VW:0] - {1'b0, div_i};
    prem_o  = qbit_o ? trial : shifted[VW:0];
  end

endmodule

// File: rtl/div_r2_iter.sv
// Iterative unsigned restoring divider with start/busy/done handshake,
// synchronous kill and divide-by-zero reporting.
// Handshake: start is only looked at in IDLE or DONE; busy is high for every
// cycle the operation is in flight; done is a one-cycle pulse during which
// quo/rem/dbz are valid (they also hold afterwards until the next completion).
module div_r2_iter
  import fpu_div_pkg::*;
#(
  parameter int DW  = 50,
  parameter int VW  = 24,
  parameter int BPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          kill,
  input  logic [DW-1:0] opa,
  input  logic [VW-1:0] opb,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          dbz
);

  localparam int ITER   = div_iter(DW, BPC);
  localparam int CW     = div_cnt_w(DW, BPC);
  localparam bit BPC_OK = div_bpc_legal(DW, VW, BPC);

  if (!BPC_OK) begin : g_bad_cfg
    $error("div_r2_iter: BPC must be 1, 2 or 4, divide DW, and VW must not exceed DW");
  end

  div_state_e    state_q, state_d;
  logic [DW-1:0] qreg_q;
  logic [VW:0]   prem_q;
  logic [VW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic          accept;
  logic          accept_dbz;
  logic          step_en;
  logic          finish;

  // Chain of BPC restoring steps evaluated in one cycle.
  logic [VW:0]   prem_c [BPC+1];
  logic [DW-1:0] qreg_c [BPC+1];

  assign prem_c[0] = prem_q;
  assign qreg_c[0] = qreg_q;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    logic qbit;
    div_r2_step #(.VW(VW)) u_step (
      .prem_i (prem_c[k]),
      .qmsb_i (qreg_c[k][DW-1]),
      .div_i  (div_q),
      .prem_o (prem_c[k+1]),
      .qbit_o (qbit)
    );
    assign qreg_c[k+1] = {qreg_c[k][DW-2:0], qbit};
  end

  // Next-state decode; kill only matters in RUN, start only in IDLE/DONE.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    accept_dbz = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (opb != '0) begin
            state_d = ST_RUN;
            accept  = 1'b1;
          end else begin
            state_d    = ST_DONE;
            accept_dbz = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working registers and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      qreg_q <= '0;
      prem_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        qreg_q <= opa;
        prem_q <= '0;
        div_q  <= opb;
        cnt_q  <= '0;
      end else if (step_en) begin
        qreg_q <= qreg_c[BPC];
        prem_q <= prem_c[BPC];
        cnt_q  <= cnt_q + CW'(1);
      end
      if (finish) begin
        quo_q <= qreg_c[BPC];
        rem_q <= prem_c[BPC][VW-1:0];
        dbz_q <= 1'b0;
      end else if (accept_dbz) begin
        quo_q <= '1;
        rem_q <= '0;
        dbz_q <= 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_r2_iter.sv
// Bench for div_r2_iter: three instances (8/4 bits at 1 and 2 bits per cycle,
// and the default 50/24 configuration) compared every cycle against a
// transaction-level model built on integer division, plus directed cases.
module tb_div_r2_iter;

  localparam int NDUT = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int DW_T   [NDUT] = '{8, 8, 50};
  localparam int VW_T   [NDUT] = '{4, 4, 24};
  localparam int ITER_T [NDUT] = '{8, 4, 50};

  // Clock / reset / shared stimulus
  logic        clk = 1'b0;
  logic        rst;
  logic        kill;
  logic [63:0] opa;
  logic [63:0] opb;
  logic        start_s [NDUT];

  always #5 clk = ~clk;

  // DUT outputs
  logic        busy_a, done_a, dbz_a, busy_b, done_b, dbz_b, busy_c, done_c, dbz_c;
  logic [7:0]  quo_a, quo_b;
  logic [3:0]  rem_a, rem_b;
  logic [49:0] quo_c;
  logic [23:0] rem_c;

  logic        busy_w [NDUT];
  logic        done_w [NDUT];
  logic        dbz_w  [NDUT];
  logic [63:0] quo_w  [NDUT];
  logic [63:0] rem_w  [NDUT];

  div_r2_iter #(.DW(8), .VW(4), .BPC(1)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .kill(kill),
    .opa(opa[7:0]), .opb(opb[3:0]),
    .busy(busy_a), .done(done_a), .quo(quo_a), .rem(rem_a), .dbz(dbz_a)
  );

  div_r2_iter #(.DW(8), .VW(4), .BPC(2)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .kill(kill),
    .opa(opa[7:0]), .opb(opb[3:0]),
    .busy(busy_b), .done(done_b), .quo(quo_b), .rem(rem_b), .dbz(dbz_b)
  );

  div_r2_iter u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .kill(kill),
    .opa(opa[49:0]), .opb(opb[23:0]),
    .busy(busy_c), .done(done_c), .quo(quo_c), .rem(rem_c), .dbz(dbz_c)
  );

  assign busy_w[0] = busy_a;  assign done_w[0] = done_a;  assign dbz_w[0] = dbz_a;
  assign busy_w[1] = busy_b;  assign done_w[1] = done_b;  assign dbz_w[1] = dbz_b;
  assign busy_w[2] = busy_c;  assign done_w[2] = done_c;  assign dbz_w[2] = dbz_c;
  assign quo_w[0] = 64'(quo_a);  assign rem_w[0] = 64'(rem_a);
  assign quo_w[1] = 64'(quo_b);  assign rem_w[1] = 64'(rem_b);
  assign quo_w[2] = 64'(quo_c);  assign rem_w[2] = 64'(rem_c);

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference model: per instance, which phase it is in, how many RUN edges
  // remain, and the result computed with plain / and %.
  int          m_mode [NDUT] = '{default: M_IDLE};
  int          m_left [NDUT] = '{default: 0};
  logic [63:0] m_pq   [NDUT] = '{default: 64'd0};
  logic [63:0] m_pr   [NDUT] = '{default: 64'd0};
  logic [63:0] m_quo  [NDUT] = '{default: 64'd0};
  logic [63:0] m_rem  [NDUT] = '{default: 64'd0};
  logic        m_dbz  [NDUT] = '{default: 1'b0};
  logic [63:0] ma, mb;

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      ma = opa & msk(DW_T[k]);
      mb = opb & msk(VW_T[k]);
      if (rst) begin
        m_mode[k] = M_IDLE;
        m_quo[k]  = 64'd0;
        m_rem[k]  = 64'd0;
        m_dbz[k]  = 1'b0;
      end else if (m_mode[k] == M_RUN) begin
        if (kill) begin
          m_mode[k] = M_IDLE;
        end else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            m_mode[k] = M_DONE;
            m_quo[k]  = m_pq[k];
            m_rem[k]  = m_pr[k];
            m_dbz[k]  = 1'b0;
          end
        end
      end else if (start_s[k]) begin
        if (mb == 64'd0) begin
          m_mode[k] = M_DONE;
          m_quo[k]  = msk(DW_T[k]);
          m_rem[k]  = 64'd0;
          m_dbz[k]  = 1'b1;
        end else begin
          m_mode[k] = M_RUN;
          m_left[k] = ITER_T[k];
          m_pq[k]   = ma / mb;
          m_pr[k]   = ma % mb;
        end
      end else begin
        m_mode[k] = M_IDLE;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("busy%0d", k), 64'(busy_w[k]), 64'(m_mode[k] == M_RUN));
      chk($sformatf("done%0d", k), 64'(done_w[k]), 64'(m_mode[k] == M_DONE));
      chk($sformatf("quo%0d", k), quo_w[k], m_quo[k]);
      chk($sformatf("rem%0d", k), rem_w[k], m_rem[k]);
      chk($sformatf("dbz%0d", k), 64'(dbz_w[k]), 64'(m_dbz[k]));
    end
  end

  // Wait (bounded) for done on instance k; lat counts edges after the accepting edge.
  task automatic wait_done(input int k, input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (!done_w[k] && lat < 200) begin
      if (busy_w[k]) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("done_seen%0d", k), 64'(done_w[k]), 64'd1);
  endtask

  // Issue one operation on instance k from an idle/done state and check it.
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] eq, input logic [63:0] er,
                        input logic ed, input string nm);
    int lat, busy_n;
    opa = a;
    opb = b;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    wait_done(k, 0, lat, busy_n);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(ed ? 0 : exp_lat));
    chk({nm, "_quo"}, quo_w[k], eq);
    chk({nm, "_rem"}, rem_w[k], er);
    chk({nm, "_dbz"}, 64'(dbz_w[k]), 64'(ed));
    chk({nm, "_model_quo"}, m_quo[k], eq);
    chk({nm, "_model_rem"}, m_rem[k], er);
  endtask

  initial begin
    int lat, busy_n;
    rst  = 1'b1;
    kill = 1'b0;
    opa  = 64'd0;
    opb  = 64'd0;
    for (int k = 0; k < NDUT; k++) start_s[k] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_done_c", 64'(done_c), 64'd0);
    chk("reset_quo_c", 64'(quo_c), 64'd0);
    chk("reset_dbz_b", 64'(dbz_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic results on each configuration, including divide by zero
    run_op(0, 64'd200, 64'd7, 8, 64'd28, 64'd4, 1'b0, "a_200_7");
    run_op(1, 64'd255, 64'd15, 4, 64'd17, 64'd0, 1'b0, "b_255_15");
    run_op(1, 64'd13, 64'd5, 4, 64'd2, 64'd3, 1'b0, "b_13_5");
    run_op(2, 64'd1 << 49, 64'd3, 50, 64'd187649984473770, 64'd2, 1'b0, "c_2p49_3");
    run_op(2, 64'd5, 64'd0, 0, (64'd1 << 50) - 64'd1, 64'd0, 1'b1, "c_5_0");
    run_op(0, 64'd5, 64'd0, 0, 64'd255, 64'd0, 1'b1, "a_5_0");
    run_op(0, 64'd255, 64'd1, 8, 64'd255, 64'd0, 1'b0, "a_255_1");

    // start during RUN is ignored; start held in DONE is accepted
    @(negedge clk);
    opa = 64'd200; opb = 64'd7; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    opa = 64'd9; opb = 64'd3; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, 3, lat, busy_n);
    chk("ignored_start_lat", 64'(lat), 64'd8);
    chk("ignored_start_quo", 64'(quo_a), 64'd28);
    chk("ignored_start_rem", 64'(rem_a), 64'd4);
    opa = 64'd9; opb = 64'd3; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("b2b_busy", 64'(busy_a), 64'd1);
    wait_done(0, 0, lat, busy_n);
    chk("b2b_lat", 64'(lat), 64'd8);
    chk("b2b_quo", 64'(quo_a), 64'd3);
    chk("b2b_rem", 64'(rem_a), 64'd0);

    // kill mid-RUN: no done, previous result retained
    run_op(0, 64'd200, 64'd7, 8, 64'd28, 64'd4, 1'b0, "a_pre_kill");
    opa = 64'd100; opb = 64'd9; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 64'(busy_a), 64'd0);
    for (int i = 0; i < 10; i++) begin
      chk("kill_no_done", 64'(done_a), 64'd0);
      @(negedge clk);
    end
    chk("kill_quo_kept", 64'(quo_a), 64'd28);
    chk("kill_rem_kept", 64'(rem_a), 64'd4);
    opa = 64'd100; opb = 64'd9; start_s[0] = 1'b1; kill = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; kill = 1'b0;
    chk("kill_start_idle_busy", 64'(busy_a), 64'd1);
    wait_done(0, 0, lat, busy_n);
    chk("kill_start_idle_quo", 64'(quo_a), 64'd11);
    chk("kill_start_idle_rem", 64'(rem_a), 64'd1);

    // reset mid-RUN, start together with reset ignored, then a clean op
    @(negedge clk);
    opa = 64'd200; opb = 64'd7; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_busy", 64'(busy_a), 64'd0);
    chk("rst_run_done", 64'(done_a), 64'd0);
    chk("rst_run_quo", 64'(quo_a), 64'd0);
    chk("rst_run_rem", 64'(rem_a), 64'd0);
    opa = 64'd9; opb = 64'd3; start_s[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_s[0] = 1'b0;
    chk("rst_start_ignored", 64'(busy_a), 64'd0);
    run_op(0, 64'd9, 64'd3, 8, 64'd3, 64'd0, 1'b0, "a_after_rst");

    // Randomized traffic on all instances against the model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0: opa = 64'hFFFF_FFFF_FFFF_FFFF;
        1: opa = 64'($urandom_range(0, 300));
        default: opa = {$urandom(), $urandom()};
      endcase
      case ($urandom_range(0, 7))
        0: opb = 64'd0;
        1: opb = 64'd1;
        2: opb = 64'hFFFF_FFFF_FFFF_FFFF;
        default: opb = {$urandom(), $urandom()};
      endcase
      for (int k = 0; k < NDUT; k++) start_s[k] = ($urandom_range(0, 3) == 0);
      kill = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    kill = 1'b0;
    for (int k = 0; k < NDUT; k++) start_s[k] = 1'b0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
